// File: rtl/ap_mult_arb.sv
// ap_mult_arb
// Round-robin scheduler in front of one shared approximate 8x8 partial-product
// compressor. Operand pairs from NREQ requesters are arbitrated into stage S1,
// whose registered operands drive the AND-array partial products (pp_o). The
// compressor result (pp_res) is captured into stage S2 and returned with the
// requester id under valid/ready backpressure.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[NREQ]   requester i has an operand pair
//   req_ready[NREQ]   one-hot grant, transfer on req_valid[i] & req_ready[i]
//   req_a, req_b      operands of requester i at [8i+:8]
//   pp_o[64]          partial products, pp_o[8i+j] = a[j] & b[i]
//   pp_res[16]        compressor result, combinational in pp_o
//   res_valid/ready   result handshake
//   res_data, res_id  approximate product and issuing requester
//   op_cnt[16]        number of results consumed, wrapping
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready may depend combinationally on req_valid; requesters must
// not make req_valid depend on req_ready. res_valid never depends on
// res_ready, and a pending result is held stable until it is consumed.
module ap_mult_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [63:0]       pp_o,
    input  logic [15:0]       pp_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       op_cnt
);

    // Stage S1
    logic [7:0]     s1_a_q, s1_a_d;
    logic [7:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s1_v_q, s1_v_d;
    // Round-robin pointer
    logic [IDW-1:0] ptr_q, ptr_d;
    // Stage S2
    logic [15:0]    res_data_q, res_data_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic           res_valid_q, res_valid_d;
    logic [15:0]    op_cnt_q, op_cnt_d;

    // Control
    logic           s2_en;
    logic           s1_free;
    logic           any_valid;
    logic           xfer;
    logic [NREQ-1:0] rot;
    logic [IDW:0]   offset;
    logic [IDW:0]   grant_sum;
    logic [IDW:0]   next_sum;
    logic [IDW-1:0] grant;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;

    assign s2_en   = !res_valid_q | res_ready;
    assign s1_free = !s1_v_q | s2_en;

    // Arbiter: rotate the request vector so that bit 0 is the requester at
    // ptr, take the lowest set bit, then map the offset back to an index.
    always_comb begin
        any_valid = |req_valid;
        rot       = NREQ'({req_valid, req_valid} >> ptr_q);
        offset    = '0;
        // Descending scan so the lowest set bit is the one that sticks.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = (IDW+1)'(k);
            end
        end
        grant_sum = {1'b0, ptr_q} + offset;
        if (grant_sum >= (IDW+1)'(NREQ)) begin
            grant_sum = grant_sum - (IDW+1)'(NREQ);
        end
        grant = grant_sum[IDW-1:0];

        next_sum = {1'b0, grant} + (IDW+1)'(1);
        if (next_sum >= (IDW+1)'(NREQ)) begin
            next_sum = '0;
        end

        xfer      = any_valid & s1_free;
        req_ready = NREQ'(xfer) << grant;
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_a = req_a[8*k +: 8];
                sel_b = req_b[8*k +: 8];
            end
        end
    end

    // Next-state for both stages, the pointer and the counter
    always_comb begin
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        s1_v_d      = s1_v_q;
        ptr_d       = ptr_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        op_cnt_d    = op_cnt_q + 16'(res_valid_q & res_ready);

        if (xfer) begin
            s1_a_d  = sel_a;
            s1_b_d  = sel_b;
            s1_id_d = grant;
            s1_v_d  = 1'b1;
            ptr_d   = next_sum[IDW-1:0];
        end else if (s1_free) begin
            // Operands are left in place; only the valid bit drops, which
            // keeps pp_o quiet between operations.
            s1_v_d = 1'b0;
        end

        if (s2_en) begin
            res_valid_d = s1_v_q;
            if (s1_v_q) begin
                res_data_d = pp_res;
                res_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            s1_v_q      <= 1'b0;
            ptr_q       <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            s1_v_q      <= s1_v_d;
            ptr_q       <= ptr_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    // AND array from the registered operands only; reset clears the operands
    // so pp_o drops to zero immediately.
    always_comb begin
        pp_o = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                pp_o[8*i + j] = s1_a_q[j] & s1_b_q[i];
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_ap_mult_arb.sv
// Testbench for ap_mult_arb: drives requesters and the result consumer,
// models the shared compressor as an exact shift-and-add of the partial
// product rows, and checks every returned result against a queue of
// expected {id, a*b} values recorded at each observed transfer.
module tb_ap_mult_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [63:0]       pp_o;
  logic [15:0]       pp_res;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic [15:0]       op_cnt;

  ap_mult_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .pp_o      (pp_o),
    .pp_res    (pp_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .op_cnt    (op_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compressor model: row r of pp_o weighted by 2^r
  always_comb begin
    pp_res = '0;
    for (int r = 0; r < 8; r++) begin
      pp_res = pp_res + (16'(pp_o[8*r +: 8]) << r);
    end
  end

  // ---------------- checking ----------------
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(res_valid), 64'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("res_data", 64'(res_data), 64'(e[15:0]));
          check("res_id", 64'(res_id), 64'(e[EW-1:16]));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({IDW'(i), 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8])});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step(2);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0]     pp_hold;
  int              accepted;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    step(2);

    // Reset values
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_pp_o", pp_o, 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_op_cnt", 64'(op_cnt), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Reset with a result pending
    set_op(2, 8'h05, 8'h07);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(1);
    check("pend_res_valid", 64'(res_valid), 64'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    check("midrst_pp_o", pp_o, 64'd0);
    step(1);
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'h2);
    req_valid = '0;
    step(1);

    // Single request from requester 1
    res_ready = 1'b1;
    set_op(1, 8'h03, 8'h05);
    req_valid = 4'b0010;
    #1;
    check("single_ready", 64'(req_ready), 64'h2);
    step(1);
    req_valid = '0;
    check("single_pp_o", pp_o, 64'h0000_0000_0003_0003);
    check("single_s2_empty", 64'(res_valid), 64'd0);
    step(1);
    check("single_res_valid", 64'(res_valid), 64'd1);
    check("single_res_id", 64'(res_id), 64'd1);
    check("single_res_data", 64'(res_data), 64'd15);
    step(1);

    // All requesters continuously valid, round-robin from 0
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      #1;
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << (c % NREQ)));
      step(1);
    end
    req_valid = '0;
    step(2);
    check("rr_op_cnt", 64'(op_cnt), 64'd8);
    check("rr_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: consumer stalled for 5 cycles
    res_ready = 1'b0;
    req_valid = 4'b1111;
    accepted  = 0;
    pp_hold   = '0;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      #1;
      if (req_ready != '0) accepted++;
      if (c == 2) pp_hold = pp_o;
      if (c > 2) check("stall_pp_stable", pp_o, pp_hold);
      step(1);
    end
    check("stall_accepted", 64'(accepted), 64'd2);
    check("stall_ready_low", 64'(req_ready), 64'd0);
    check("stall_res_valid", 64'(res_valid), 64'd1);
    check("stall_in_flight", 64'(exp_q.size()), 64'd2);
    req_valid = '0;
    res_ready = 1'b1;
    step(3);
    check("stall_drained", 64'(exp_q.size()), 64'd0);
    check("stall_op_cnt", 64'(op_cnt), 64'd10);

    // Zero operand from requester 3
    set_op(3, 8'h00, 8'hFF);
    req_valid = 4'b1000;
    #1;
    check("zero_ready", 64'(req_ready), 64'h8);
    step(1);
    req_valid = '0;
    check("zero_pp_o", pp_o, 64'd0);
    step(1);
    check("zero_res_valid", 64'(res_valid), 64'd1);
    check("zero_res_data", 64'(res_data), 64'd0);
    check("zero_res_id", 64'(res_id), 64'd3);
    step(1);

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      res_ready = 1'($urandom_range(0, 1));
      #1;
      check("rand_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      check("rand_grant_valid", 64'((req_ready & ~req_valid) == '0), 64'd1);
      step(1);
    end
    req_valid = '0;
    res_ready = 1'b1;
    step(3);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // op_cnt wrap
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    for (int c = 0; c < 65536; c++) begin
      set_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step(1);
    end
    req_valid = '0;
    check("wrap_pre", 64'(op_cnt), 64'hFFFE);
    step(2);
    check("wrap_op_cnt", 64'(op_cnt), 64'h0000);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
